// File: rtl/siso_maxlog.sv
// Max-log-MAP SISO for the 4-state RSC (7,5) constituent code: forward recursion while loading, backward on output.
// Optional SISO_APP_OUT_EN adds app_o carrying the saturated a-posteriori LLR.
module siso_maxlog #(
  parameter int W      = 8,
  parameter int AW     = 12,
  parameter int N      = 64,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic                 clk_p_i,
  input  logic                 reset_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [W-1:0]  sys_i,
  input  logic signed [W-1:0]  par_i,
  input  logic signed [W-1:0]  apr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic signed [W-1:0]  ext_o,
  output logic [ADDR_W-1:0]    out_idx_o,
  output logic                 out_last_o,
`ifdef SISO_APP_OUT_EN
  output logic signed [W-1:0]  app_o,
`endif
  output logic                 busy_o
);

  typedef logic signed [AW-1:0] metric_t;
  typedef logic signed [W-1:0]  llr_t;
  typedef enum logic {LOAD, BACK} state_t;

  localparam metric_t M_MAX    = {1'b0, {(AW-1){1'b1}}};
  localparam metric_t M_MIN    = {1'b1, {(AW-1){1'b0}}};
  localparam metric_t INIT_NEG = {2'b11, {(AW-2){1'b0}}};
  localparam metric_t W_MAX    = metric_t'((2**(W-1)) - 1);
  localparam metric_t W_MIN    = metric_t'(-(2**(W-1)));

  function automatic metric_t sat_add(input metric_t a, input metric_t b);
    logic signed [AW:0] s;
    s = (AW+1)'(a) + (AW+1)'(b);
    if (s[AW] != s[AW-1]) return s[AW] ? M_MIN : M_MAX;
    return s[AW-1:0];
  endfunction

  function automatic metric_t sat_sub(input metric_t a, input metric_t b);
    logic signed [AW:0] s;
    s = (AW+1)'(a) - (AW+1)'(b);
    if (s[AW] != s[AW-1]) return s[AW] ? M_MIN : M_MAX;
    return s[AW-1:0];
  endfunction

  function automatic llr_t sat_w(input metric_t x);
    if (x > W_MAX) return W_MAX[W-1:0];
    if (x < W_MIN) return W_MIN[W-1:0];
    return x[W-1:0];
  endfunction

  // Trellis of the (7,5) RSC: state {d1,d2}, a = u^d1^d2, parity = a^d2 = u^d1.
  function automatic logic [1:0] nxt(input logic [1:0] s, input logic u);
    return {u ^ s[1] ^ s[0], s[1]};
  endfunction

  function automatic logic pbit(input logic [1:0] s, input logic u);
    return u ^ s[1];
  endfunction

  function automatic metric_t gam(input logic u, input logic p, input metric_t lsa, input metric_t par);
    metric_t gu, gp;
    gu = u ? lsa : '0;
    gp = p ? par : '0;
    return sat_add(gu, gp);
  endfunction

  state_t              state;
  logic [ADDR_W-1:0]   k;
  metric_t             alpha_cur [4];
  metric_t             beta_cur  [4];
  metric_t             alpha_nxt [4];
  metric_t             beta_nxt  [4];
  metric_t             acc_f     [4];
  metric_t             acc_b     [4];

  llr_t                sys_mem   [N];
  llr_t                par_mem   [N];
  llr_t                apr_mem   [N];
  metric_t             alpha_mem [N][4];

  metric_t             lsa_in, par_in, lsa_k, par_k;
  metric_t             m1, m0, l_app, ext_full, cand_f, cand_b, br;
  logic [1:0]          ns_f, ns_b;

  assign lsa_in = metric_t'(sys_i) + metric_t'(apr_i);
  assign par_in = metric_t'(par_i);
  assign lsa_k  = metric_t'(sys_mem[k]) + metric_t'(apr_mem[k]);
  assign par_k  = metric_t'(par_mem[k]);

  // Forward step: add-compare-select into each successor, then normalise to state 0.
  always_comb begin
    ns_f   = '0;
    cand_f = '0;
    for (int t = 0; t < 4; t++) acc_f[t] = M_MIN;
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        ns_f   = nxt(2'(s), 1'(u));
        cand_f = sat_add(alpha_cur[s], gam(1'(u), pbit(2'(s), 1'(u)), lsa_in, par_in));
        if (cand_f > acc_f[ns_f]) acc_f[ns_f] = cand_f;
      end
    end
    for (int t = 0; t < 4; t++) alpha_nxt[t] = sat_sub(acc_f[t], acc_f[0]);
  end

  // Backward step and LLR for the stored entry k, using alpha_k and beta_{k+1}.
  always_comb begin
    ns_b   = '0;
    cand_b = '0;
    br     = '0;
    m1     = M_MIN;
    m0     = M_MIN;
    for (int t = 0; t < 4; t++) acc_b[t] = M_MIN;
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        ns_b   = nxt(2'(s), 1'(u));
        br     = gam(1'(u), pbit(2'(s), 1'(u)), lsa_k, par_k);
        cand_b = sat_add(beta_cur[ns_b], br);
        if (cand_b > acc_b[s]) acc_b[s] = cand_b;
        cand_b = sat_add(sat_add(alpha_mem[k][s], br), beta_cur[ns_b]);
        if (u == 1) begin
          if (cand_b > m1) m1 = cand_b;
        end else begin
          if (cand_b > m0) m0 = cand_b;
        end
      end
    end
    for (int t = 0; t < 4; t++) beta_nxt[t] = sat_sub(acc_b[t], acc_b[0]);
    l_app    = sat_sub(m1, m0);
    ext_full = sat_sub(l_app, lsa_k);
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= LOAD;
      k     <= '0;
      for (int t = 0; t < 4; t++) begin
        alpha_cur[t] <= (t == 0) ? '0 : INIT_NEG;
        beta_cur[t]  <= '0;
      end
    end else begin
      case (state)
        LOAD: if (in_valid_i) begin
          for (int t = 0; t < 4; t++) alpha_cur[t] <= alpha_nxt[t];
          if (k == ADDR_W'(N-1)) state <= BACK;
          else                   k     <= k + ADDR_W'(1);
        end
        BACK: if (out_ready_i) begin
          if (k == '0) begin
            state <= LOAD;
            for (int t = 0; t < 4; t++) begin
              alpha_cur[t] <= (t == 0) ? '0 : INIT_NEG;
              beta_cur[t]  <= '0;
            end
          end else begin
            k <= k - ADDR_W'(1);
            for (int t = 0; t < 4; t++) beta_cur[t] <= beta_nxt[t];
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Frame storage carries no reset; entries are always written before being read.
  always_ff @(posedge clk_p_i) begin
    if (state == LOAD && in_valid_i) begin
      sys_mem[k] <= sys_i;
      par_mem[k] <= par_i;
      apr_mem[k] <= apr_i;
      for (int t = 0; t < 4; t++) alpha_mem[k][t] <= alpha_cur[t];
    end
  end

  assign in_ready_o  = (state == LOAD);
  assign out_valid_o = (state == BACK);
  assign out_idx_o   = (state == BACK) ? k : '0;
  assign out_last_o  = (state == BACK) && (k == '0);
  assign ext_o       = (state == BACK) ? sat_w(ext_full) : '0;
  assign busy_o      = (state == BACK) || (k != '0);
`ifdef SISO_APP_OUT_EN
  assign app_o       = (state == BACK) ? sat_w(l_app) : '0;
`endif

endmodule

// File: tb/tb_siso_maxlog.sv
// Directed bench for siso_maxlog (W=8, AW=12, N=64) with hand-derived extrinsic values.
module tb_siso_maxlog;
  localparam int W = 8, AW = 12, N = 64, AWI = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [7:0] sys, par, apr, ext;
  logic [AWI-1:0]    out_idx;
`ifdef SISO_APP_OUT_EN
  logic signed [7:0] app;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cycles   = 0;
  int cyc_start;

  siso_maxlog #(.W(W), .AW(AW), .N(N)) dut (
    .clk_p_i(clk), .reset_n_i(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sys_i(sys), .par_i(par), .apr_i(apr),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ext_o(ext), .out_idx_o(out_idx), .out_last_o(out_last),
`ifdef SISO_APP_OUT_EN
    .app_o(app),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles <= cycles + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Steady-state alpha {0,-60,-40,-60}; beta converges to {0,-40,-60,-60} within five backward steps.
  function automatic int exp_zero(input int idx);
    if (idx == 63) return -20;
    if (idx >= 61) return -40;
    if (idx >= 59) return -60;
    return -80;
  endfunction

  task automatic load_frame(input int s, input int p, input int a, input int count);
    for (int i = 0; i < count; i++) begin
      if (i == 0) check("in_ready_load", in_ready, 1);
      sys = 8'(s); par = 8'(p); apr = 8'(a);
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 0) check("busy_after_first", busy, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic unload(input int mode, input bit stall, input int stop_idx);
    int exp_idx, hs, guard;
    logic signed [7:0] prev_ext;
    logic [AWI-1:0]    prev_idx;
    bit stalled;
    exp_idx = N-1; hs = 0; guard = 0; stalled = 0;
    prev_ext = '0; prev_idx = '0;
    while (exp_idx >= 0 && exp_idx != stop_idx && guard < 2000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, exp_idx);
      check("out_last", out_last, exp_idx == 0);
      case (mode)
        0: check("ext_zero", ext, exp_zero(exp_idx));
        1: check("ext_erasure", ext, 0);
        default: begin
          check("ext_sat_nonpos", ext <= 0, 1);
          if (exp_idx == N-1) check("ext_sat_first", ext, -128);
`ifdef SISO_APP_OUT_EN
          check("app_sat", app, -128);
`endif
        end
      endcase
      if (stalled) begin
        check("hold_ext", ext, prev_ext);
        check("hold_idx", out_idx, prev_idx);
      end
      prev_ext = ext; prev_idx = out_idx;
      @(posedge clk); #1;
      guard++;
      if (out_ready) begin hs++; exp_idx--; stalled = 0; end
      else stalled = 1;
    end
    out_ready = 1'b0;
    check("unload_end_idx", exp_idx, (stop_idx >= 0) ? stop_idx : -1);
    if (stop_idx < 0) check("handshakes", hs, N);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ext"}, ext, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 0);
`ifdef SISO_APP_OUT_EN
    check({tag, "_app"}, app, 0);
`endif
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sys = '0; par = '0; apr = '0;
    #12;
    check_reset_state("por");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // All-zero codeword, unstalled, with latency and frame-length checks.
    cyc_start = cycles;
    load_frame(-20, -20, 0, N);
    check("latency_valid", out_valid, 1);
    check("latency_idx", out_idx, N-1);
    check("back_in_ready", in_ready, 0);
    unload(0, 1'b0, -1);
    check("frame_cycles", cycles - cyc_start, 2*N);
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);

    // Erasure frame, back to back.
    load_frame(0, 0, 0, N);
    unload(1, 1'b0, -1);

    // Backpressure on the all-zero codeword.
    load_frame(-20, -20, 0, N);
    unload(0, 1'b1, -1);

    // Saturating inputs.
    load_frame(-128, -128, -128, N);
    unload(2, 1'b0, -1);

    // Reset while outputting index 30, then a clean frame.
    load_frame(-20, -20, 0, N);
    unload(0, 1'b0, 30);
    check("pre_reset_idx", out_idx, 30);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check_reset_state("rst_back");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    load_frame(-20, -20, 0, N);
    unload(0, 1'b0, -1);

    // Asynchronous reset mid-cycle during load.
    load_frame(-20, -20, 0, 10);
    check("partial_busy", busy, 1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("rst_load");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    load_frame(-20, -20, 0, N);
    unload(0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=%0d expected=%0d", cycles, 0);
    $fatal(1, "timeout");
  end

endmodule
